// File: rtl/operand_mux_arbiter.sv
// Round-robin arbiter sharing one operand-select mux among NUM_REQ requesters.
// Each grant drives the selection, waits one settle cycle, then returns the captured result.
module operand_mux_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = 17,
    parameter int PARK_SEL = 0,
    parameter int MAX_SEL  = 6
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic [NUM_REQ-1:0]     Req,
    input  logic [4*NUM_REQ-1:0]   ReqSel,
    output logic [NUM_REQ-1:0]     Gnt,
    output logic [DATA_W-1:0]      RdData,
    output logic                   SelError,
    output logic                   Busy,
    output logic [3:0]             MuxSelection,
    input  logic [DATA_W-1:0]      MuxOutput
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SELECT, GRANT} state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [DATA_W-1:0]   rd_q;
    logic                err_q;
    logic                busy_q;
    logic [3:0]          sel_q;
    logic [PW-1:0]       ptr_q;
    logic [PW-1:0]       owner_q;

    logic                win_vld;
    logic [PW-1:0]       win_idx;
    logic [PW-1:0]       cand;

    // Descending scan so the candidate closest to the pointer is the last one kept.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (Req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            sel_q   <= 4'(PARK_SEL);
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        owner_q <= win_idx;
                        sel_q   <= ReqSel[4*win_idx +: 4];
                        busy_q  <= 1'b1;
                        state_q <= SELECT;
                    end
                end
                SELECT: begin
                    if (sel_q <= 4'(MAX_SEL)) begin
                        rd_q  <= MuxOutput;
                        err_q <= 1'b0;
                    end else begin
                        rd_q  <= '0;
                        err_q <= 1'b1;
                    end
                    gnt_q   <= NUM_REQ'(1) << owner_q;
                    state_q <= GRANT;
                end
                GRANT: begin
                    gnt_q   <= '0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    ptr_q   <= (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Gnt          = gnt_q;
    assign RdData       = rd_q;
    assign SelError     = err_q;
    assign Busy         = busy_q;
    assign MuxSelection = sel_q;
endmodule

// File: tb/tb_operand_mux_arbiter.sv
// Bench for operand_mux_arbiter: directed vector table, hand sequences and random traffic
// checked against a transaction-schedule reference model.
module tb_operand_mux_arbiter;
    localparam int N    = 3;
    localparam int DW   = 17;
    localparam int MAXS = 6;

    logic            Clock;
    logic            Reset_n;
    logic [N-1:0]    Req;
    logic [4*N-1:0]  ReqSel;
    logic [N-1:0]    Gnt;
    logic [DW-1:0]   RdData;
    logic            SelError;
    logic            Busy;
    logic [3:0]      MuxSelection;
    logic [DW-1:0]   MuxOutput;

    logic [DW-1:0] in1, in2, in3, pc;

    int errs   = 0;
    int checks = 0;

    operand_mux_arbiter #(.NUM_REQ(N), .DATA_W(DW), .PARK_SEL(0), .MAX_SEL(MAXS)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Req(Req), .ReqSel(ReqSel), .Gnt(Gnt),
        .RdData(RdData), .SelError(SelError), .Busy(Busy),
        .MuxSelection(MuxSelection), .MuxOutput(MuxOutput)
    );

    function automatic logic [DW-1:0] mux(input logic [3:0] s);
        case (s)
            4'd0: return in1;
            4'd1: return in2;
            4'd2: return in3;
            4'd3: return 17'h0005F;
            4'd4: return 17'h000C8;
            4'd5: return 17'h1FFFF;
            4'd6: return pc;
            default: return 17'h0AAAA;
        endcase
    endfunction

    assign MuxOutput = mux(MuxSelection);

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a granted transaction occupies three edges starting at t0.
    int m_cyc, m_t0, m_free_at, m_ptr, m_win;
    logic [3:0]    m_sel;
    logic [N-1:0]  e_gnt;
    logic [DW-1:0] e_rd;
    logic          e_err, e_busy;
    logic [3:0]    e_sel;

    task automatic model_reset();
        m_cyc = 0; m_t0 = -10; m_free_at = 0; m_ptr = 0; m_win = 0; m_sel = 0;
        e_gnt = '0; e_rd = '0; e_err = 1'b0; e_busy = 1'b0; e_sel = 4'd0;
    endtask

    task automatic model_step();
        if (!Reset_n) begin
            model_reset();
            return;
        end
        m_cyc++;
        if (m_cyc == m_t0 + 1) begin
            e_gnt  = N'(1) << m_win;
            e_err  = (m_sel > MAXS);
            e_rd   = e_err ? '0 : mux(m_sel);
        end else if (m_cyc == m_t0 + 2) begin
            e_gnt  = '0;
            e_err  = 1'b0;
            e_busy = 1'b0;
        end else if (m_cyc >= m_free_at && Req != '0) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (Req[i]) begin
                    m_win = i;
                    break;
                end
            end
            m_sel     = ReqSel[4*m_win +: 4];
            e_sel     = m_sel;
            e_busy    = 1'b1;
            m_t0      = m_cyc;
            m_free_at = m_cyc + 3;
            m_ptr     = (m_win + 1) % N;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("model.Gnt", 32'(Gnt), 32'(e_gnt));
        chk("model.RdData", 32'(RdData), 32'(e_rd));
        chk("model.SelError", 32'(SelError), 32'(e_err));
        chk("model.Busy", 32'(Busy), 32'(e_busy));
        chk("model.MuxSelection", 32'(MuxSelection), 32'(e_sel));
    endtask

    task automatic tick();
        @(posedge Clock);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        model_reset();
        repeat (2) tick();
        Reset_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0]   req;
        logic [4*N-1:0] sel;   // {sel2, sel1, sel0}
        logic [N-1:0]   gnt;
        logic [DW-1:0]  rd;
        logic           err;
    } vec_t;

    vec_t tbl[11];

    logic [N-1:0]  rr_g[$];
    logic [DW-1:0] rr_d[$];
    int            rr_c[$];

    initial begin
        tbl[0]  = '{3'b010, {4'd0, 4'd6, 4'd0},  3'b010, 17'h1A2B3, 1'b0};
        tbl[1]  = '{3'b001, {4'd0, 4'd0, 4'd9},  3'b001, 17'h00000, 1'b1};
        tbl[2]  = '{3'b001, {4'd0, 4'd0, 4'd3},  3'b001, 17'h0005F, 1'b0};
        tbl[3]  = '{3'b101, {4'd4, 4'd0, 4'd0},  3'b100, 17'h000C8, 1'b0};
        tbl[4]  = '{3'b101, {4'd5, 4'd0, 4'd1},  3'b001, 17'h00022, 1'b0};
        tbl[5]  = '{3'b101, {4'd2, 4'd0, 4'd1},  3'b100, 17'h00033, 1'b0};
        tbl[6]  = '{3'b110, {4'd5, 4'd0, 4'd0},  3'b010, 17'h00011, 1'b0};
        tbl[7]  = '{3'b011, {4'd0, 4'd0, 4'd5},  3'b001, 17'h1FFFF, 1'b0};
        tbl[8]  = '{3'b100, {4'd15, 4'd0, 4'd0}, 3'b100, 17'h00000, 1'b1};
        tbl[9]  = '{3'b111, {4'd0, 4'd0, 4'd7},  3'b001, 17'h00000, 1'b1};
        tbl[10] = '{3'b111, {4'd0, 4'd6, 4'd0},  3'b010, 17'h1A2B3, 1'b0};

        in1 = 17'h00011; in2 = 17'h00022; in3 = 17'h00033; pc = 17'h1A2B3;
        Reset_n = 1'b0; Req = 3'b111; ReqSel = '0;
        model_reset();
        #1;
        chk("reset.MuxSelection", 32'(MuxSelection), 32'd0);
        chk("reset.Gnt", 32'(Gnt), 32'd0);
        chk("reset.RdData", 32'(RdData), 32'd0);
        chk("reset.Busy", 32'(Busy), 32'd0);
        repeat (3) tick();
        Reset_n = 1'b1; Req = '0;
        repeat (5) tick();

        // Directed vector table, pointer state carries from row to row.
        for (int r = 0; r < 11; r++) begin
            Req = tbl[r].req; ReqSel = tbl[r].sel;
            tick();
            tick();
            chk($sformatf("tbl%0d.Gnt", r), 32'(Gnt), 32'(tbl[r].gnt));
            chk($sformatf("tbl%0d.RdData", r), 32'(RdData), 32'(tbl[r].rd));
            chk($sformatf("tbl%0d.SelError", r), 32'(SelError), 32'(tbl[r].err));
            Req = '0;
            tick();
            chk($sformatf("tbl%0d.GntClear", r), 32'(Gnt), 32'd0);
            tick();
        end

        // Round-robin with all three requesters holding Req.
        do_reset();
        Req = 3'b111; ReqSel = {4'd5, 4'd4, 4'd3};
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (Gnt != '0) begin
                rr_g.push_back(Gnt); rr_d.push_back(RdData); rr_c.push_back(c);
            end
        end
        chk("rr.count", 32'(rr_g.size()), 32'd4);
        if (rr_g.size() == 4) begin
            chk("rr.g0", 32'(rr_g[0]), 32'b001); chk("rr.d0", 32'(rr_d[0]), 32'h0005F);
            chk("rr.g1", 32'(rr_g[1]), 32'b010); chk("rr.d1", 32'(rr_d[1]), 32'h000C8);
            chk("rr.g2", 32'(rr_g[2]), 32'b100); chk("rr.d2", 32'(rr_d[2]), 32'h1FFFF);
            chk("rr.g3", 32'(rr_g[3]), 32'b001); chk("rr.d3", 32'(rr_d[3]), 32'h0005F);
            chk("rr.spacing", 32'(rr_c[3] - rr_c[0]), 32'd9);
        end
        Req = '0;
        repeat (3) tick();

        // Reset during SELECT of R1 aborts the grant and clears the pointer.
        do_reset();
        Req = 3'b010; ReqSel = {4'd0, 4'd4, 4'd0};
        tick();
        chk("abort.BusyInSelect", 32'(Busy), 32'd1);
        Reset_n = 1'b0;
        model_reset();
        #1;
        chk("abort.Busy", 32'(Busy), 32'd0);
        chk("abort.Gnt", 32'(Gnt), 32'd0);
        chk("abort.MuxSelection", 32'(MuxSelection), 32'd0);
        repeat (2) tick();
        Reset_n = 1'b1; Req = '0;
        repeat (3) tick();
        Req = 3'b011; ReqSel = {4'd0, 4'd4, 4'd3};
        tick();
        tick();
        chk("abort.firstGnt", 32'(Gnt), 32'b001);
        chk("abort.firstRd", 32'(RdData), 32'h0005F);
        Req = '0;
        repeat (3) tick();

        // Random traffic, including withdrawn requests and illegal codes.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) Req = N'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) ReqSel = 12'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                in1 = 17'($urandom); in2 = 17'($urandom);
                in3 = 17'($urandom); pc  = 17'($urandom);
            end
            if ($urandom_range(0, 499) == 0) begin
                Reset_n = 1'b0;
                model_reset();
                #1;
                check_model();
                tick();
                Reset_n = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
